// File: rtl/router_output_arbiter_if.sv
// Output-port bundle: requester side, link side, VC phase and occupancy.
// Wires only, so there is no latency.
// Link flow is a send/ready handshake; requesters hold req_valid until they are granted.
interface router_output_arbiter_if #(
    parameter int NUM_REQ = 5,
    parameter int DATA_W  = 64
);
    logic                      polarity;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        grant;
    logic                      out_ready;
    logic                      out_send;
    logic [DATA_W-1:0]         out_data;
    logic [1:0]                vc_full;

    modport master (
        output polarity, req_valid, req_data, out_ready,
        input  grant, out_send, out_data, vc_full
    );

    modport slave (
        input  polarity, req_valid, req_data, out_ready,
        output grant, out_send, out_data, vc_full
    );
endinterface

// File: rtl/router_output_arbiter.sv
// Round-robin output-port arbiter with one single-flit buffer per VC, using polarity-phased fill and drain.
// A flit granted in cycle t is captured at edge t and can leave on the link in cycle t+1.
// When out_ready is low the drain VC holds its flit, and that VC takes no grants until it empties.
module router_output_arbiter #(
    parameter int NUM_REQ = 5,
    parameter int DATA_W  = 64,
    parameter int PTR_W   = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    router_output_arbiter_if.slave bus
);

    logic [DATA_W-1:0] vc_buf [2];
    logic [PTR_W-1:0]  rr_ptr [2];
    logic [1:0]        vc_full_q;

    logic              fill_vc;
    logic              drain_vc;
    logic              win_vld;
    logic [PTR_W-1:0]  win_idx;
    logic [PTR_W-1:0]  win_nxt;
    logic [DATA_W-1:0] win_dat;
    logic              send;

    // The VC selected by polarity fills this cycle, and the other VC drains.
    assign fill_vc  = bus.polarity;
    assign drain_vc = ~bus.polarity;

    // Round-robin scan that starts at the fill VC pointer. It never looks at out_ready.
    always_comb begin
        int               cand;
        logic [PTR_W-1:0] cand_idx;
        win_vld  = 1'b0;
        win_idx  = '0;
        cand     = 0;
        cand_idx = '0;
        if (!reset && !vc_full_q[fill_vc]) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand = int'(rr_ptr[fill_vc]) + k;
                if (cand >= NUM_REQ) begin
                    cand = cand - NUM_REQ;
                end
                cand_idx = PTR_W'(cand);
                if (!win_vld && bus.req_valid[cand_idx]) begin
                    win_vld = 1'b1;
                    win_idx = cand_idx;
                end
            end
        end
    end

    // Drive the one-hot grant, select the winning flit, and compute the pointer with wrap.
    always_comb begin
        bus.grant = '0;
        win_dat   = '0;
        win_nxt   = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_vld && (i == int'(win_idx))) begin
                bus.grant[i] = 1'b1;
                win_dat      = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // The drain side depends only on registered occupancy and out_ready, never on req_valid.
    assign send         = !reset && vc_full_q[drain_vc] && bus.out_ready;
    assign bus.out_send = send;
    assign bus.out_data = send ? vc_buf[drain_vc] : '0;
    assign bus.vc_full  = vc_full_q;

    // State update: fill and drain always target different VCs in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            vc_full_q <= 2'b00;
            vc_buf[0] <= '0;
            vc_buf[1] <= '0;
            rr_ptr[0] <= '0;
            rr_ptr[1] <= '0;
        end else begin
            if (win_vld) begin
                vc_buf[fill_vc]    <= win_dat;
                vc_full_q[fill_vc] <= 1'b1;
                rr_ptr[fill_vc]    <= win_nxt;
            end
            if (send) begin
                vc_full_q[drain_vc] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_router_output_arbiter.sv
// Directed bench for router_output_arbiter, with hand-computed expectations.
// Inputs change 1 time unit after each rising edge, and checks are made 1 unit later.
// Any check that differs prints a FAIL line, and the run then goes on to the summary.
module tb_router_output_arbiter;

    localparam int NUM_REQ = 5;
    localparam int DATA_W  = 64;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [DATA_W-1:0] dat [NUM_REQ];

    router_output_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

    router_output_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .PTR_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to the next cycle, then apply that cycle's inputs and the current flit table.
    task automatic drive(input logic rst, input logic pol, input logic [NUM_REQ-1:0] rv,
                         input logic rdy);
        @(posedge clk);
        #1;
        reset         = rst;
        bus.polarity  = pol;
        bus.req_valid = rv;
        bus.out_ready = rdy;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_data[i*DATA_W +: DATA_W] = dat[i];
        end
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int               prev;
        int               k;
        logic             pol;
        logic [4:0]       rv;

        for (int i = 0; i < NUM_REQ; i++) begin
            dat[i] = 64'hC0DE_0000_0000_0000 | 64'(i);
        end
        reset         = 1'b1;
        bus.polarity  = 1'b0;
        bus.req_valid = 5'b11111;
        bus.out_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_data[i*DATA_W +: DATA_W] = dat[i];
        end
        #1;
        chk("rst0_grant", 64'(bus.grant), 64'h0);
        chk("rst0_send",  64'(bus.out_send), 64'h0);
        chk("rst0_data",  bus.out_data, 64'h0);

        drive(1'b1, 1'b1, 5'b11111, 1'b1);
        chk("rst1_grant", 64'(bus.grant), 64'h0);
        chk("rst1_send",  64'(bus.out_send), 64'h0);
        chk("rst1_data",  bus.out_data, 64'h0);
        chk("rst1_full",  64'(bus.vc_full), 64'h0);

        // Both VCs saturated: each VC walks 0,1,2,3,4,0 on its own pointer.
        prev = 0;
        for (int c = 0; c < 12; c++) begin
            k   = c / 2;
            pol = (c % 2) == 1;
            drive(1'b0, pol, 5'b11111, 1'b1);
            chk($sformatf("rr%0d_grant", c), 64'(bus.grant), 64'(5'b00001 << (k % 5)));
            if (c == 0) begin
                chk("rr0_send", 64'(bus.out_send), 64'h0);
            end else begin
                chk($sformatf("rr%0d_send", c), 64'(bus.out_send), 64'h1);
                chk($sformatf("rr%0d_data", c), bus.out_data, 64'hC0DE_0000_0000_0000 | 64'(prev));
            end
            prev = k % 5;
        end

        // Stall the link so that both VCs are full, then reset mid-operation.
        drive(1'b0, 1'b0, 5'b11111, 1'b0);
        chk("full_grant", 64'(bus.grant), 64'(5'b00010));
        chk("full_vc",    64'(bus.vc_full), 64'h2);
        chk("full_send",  64'(bus.out_send), 64'h0);
        drive(1'b1, 1'b1, 5'b11111, 1'b1);
        chk("mrst_vc",    64'(bus.vc_full), 64'h3);
        chk("mrst_grant", 64'(bus.grant), 64'h0);
        chk("mrst_send",  64'(bus.out_send), 64'h0);
        chk("mrst_data",  bus.out_data, 64'h0);
        drive(1'b0, 1'b0, 5'b00000, 1'b1);
        chk("post_vc",    64'(bus.vc_full), 64'h0);
        chk("post_send0", 64'(bus.out_send), 64'h0);
        drive(1'b0, 1'b1, 5'b00000, 1'b1);
        chk("post_send1", 64'(bus.out_send), 64'h0);
        chk("post_data1", bus.out_data, 64'h0);

        // Single flit through vc0. This also leaves rr_ptr[0] at 3.
        dat[2] = 64'hA5;
        drive(1'b0, 1'b0, 5'b00100, 1'b1);
        chk("one_grant", 64'(bus.grant), 64'(5'b00100));
        chk("one_send0", 64'(bus.out_send), 64'h0);
        drive(1'b0, 1'b1, 5'b00000, 1'b1);
        chk("one_vc1",   64'(bus.vc_full), 64'h1);
        chk("one_send1", 64'(bus.out_send), 64'h1);
        chk("one_data",  bus.out_data, 64'hA5);
        chk("one_gidle", 64'(bus.grant), 64'h0);
        drive(1'b0, 1'b0, 5'b00000, 1'b1);
        chk("one_vc2",   64'(bus.vc_full), 64'h0);
        chk("one_send2", 64'(bus.out_send), 64'h0);
        drive(1'b0, 1'b1, 5'b00000, 1'b1);

        // The pointer is at 3 while only requesters 0 and 1 are active, so the scan wraps to 0.
        dat[0] = 64'h22;
        dat[1] = 64'h33;
        drive(1'b0, 1'b0, 5'b00011, 1'b1);
        chk("skip_grant", 64'(bus.grant), 64'(5'b00001));
        drive(1'b0, 1'b1, 5'b00000, 1'b1);
        chk("skip_data0", bus.out_data, 64'h22);
        drive(1'b0, 1'b0, 5'b00011, 1'b1);
        chk("skip_ptr", 64'(bus.grant), 64'(5'b00010));
        drive(1'b0, 1'b1, 5'b00000, 1'b1);
        chk("skip_data1", bus.out_data, 64'h33);

        // Backpressure: vc0 holds 0x11 for six cycles while vc1 takes one flit.
        dat[2] = 64'h11;
        drive(1'b0, 1'b0, 5'b00100, 1'b0);
        chk("bp_fill", 64'(bus.grant), 64'(5'b00100));
        dat[2] = 64'h44;
        dat[3] = 64'h55;
        for (int j = 0; j < 6; j++) begin
            pol = (j % 2) == 0;
            rv  = pol ? 5'b01000 : 5'b00100;
            if (j > 0) begin
                rv = pol ? 5'b00000 : 5'b00100;
            end
            drive(1'b0, pol, rv, 1'b0);
            chk($sformatf("bp%0d_grant", j), 64'(bus.grant), (j == 0) ? 64'(5'b01000) : 64'h0);
            chk($sformatf("bp%0d_vc", j),    64'(bus.vc_full), (j == 0) ? 64'h1 : 64'h3);
            chk($sformatf("bp%0d_send", j),  64'(bus.out_send), 64'h0);
        end
        drive(1'b0, 1'b1, 5'b00000, 1'b1);
        chk("bp_rel_send",  64'(bus.out_send), 64'h1);
        chk("bp_rel_data",  bus.out_data, 64'h11);
        chk("bp_rel_grant", 64'(bus.grant), 64'h0);
        drive(1'b0, 1'b0, 5'b00100, 1'b1);
        chk("bp_refill", 64'(bus.grant), 64'(5'b00100));
        chk("bp_vc1_data", bus.out_data, 64'h55);
        drive(1'b0, 1'b1, 5'b00000, 1'b1);
        chk("bp_vc0_send", 64'(bus.out_send), 64'h1);
        chk("bp_vc0_data", bus.out_data, 64'h44);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/router_output_arbiter.md
# router_output_arbiter

Per-output-port arbiter for the mesh router. It shares one outgoing 64-bit link among the router's input channels (N, S, E, W, PE) that want this port. It keeps one single-flit buffer per virtual channel, selected by the global polarity bit, and grants requesters round-robin. One instance sits in front of each output port and drains onto the link with a send/ready handshake.

## Interface
- NUM_REQ, 5, number of requesting input channels; must be ≥ 2.
- DATA_W, 64, flit width.
- PTR_W, 3, round-robin pointer width; must satisfy 2^PTR_W ≥ NUM_REQ.
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- polarity  input  1  global VC phase; toggles every cycle. 0 = even VC (vc0), 1 = odd VC (vc1).
- req_valid  input  NUM_REQ  bit i high: requester i offers a flit for this port in the current polarity's VC.
- req_data  input  NUM_REQ*DATA_W  flit of requester i at bits [i*DATA_W +: DATA_W].
- grant  output  NUM_REQ  one-hot or zero, combinational. Bit i high: requester i's flit is captured at this edge.
- out_ready  input  1  downstream can accept a flit this cycle.
- out_send  output  1  combinational; flit on out_data is transferred at this edge.
- out_data  output  DATA_W  outgoing flit; 0 when out_send is low.
- vc_full  output  2  registered occupancy of vc1/vc0 (bit 1 = vc1, bit 0 = vc0).

## Operation
- State:
  - buffers buf[0], buf[1] (DATA_W each)
  - full flags vc_full[1:0]
  - round-robin pointers rr_ptr[0], rr_ptr[1] (PTR_W each)
- Phase rule: in a cycle with polarity = p, VC p is in fill phase and VC ~p is in drain phase. A VC never fills and drains in the same cycle.
- Fill, VC p:
  - Arbitration runs only when vc_full[p] = 0 and req_valid ≠ 0.
  - Winner = first index i with req_valid[i] = 1, scanning rr_ptr[p], rr_ptr[p]+1, … modulo NUM_REQ.
  - grant[i] = 1 combinationally. At the edge: buf[p] ← req_data[i], vc_full[p] ← 1, rr_ptr[p] ← (i+1) mod NUM_REQ.
  - If vc_full[p] = 1 or no request: grant = 0, and rr_ptr[p] is unchanged.
- Drain, VC q = ~p:
  - out_send = vc_full[q] & out_ready; out_data = buf[q] when out_send, else 0.
  - On out_send: vc_full[q] ← 0 at the edge. buf[q] keeps its value (don't-care while empty).
  - If out_ready = 0, the flit is held and retried on the next cycle with polarity = p.
- Requesters drop a flit only when they see grant; a non-granted requester keeps req_valid asserted.
- The pointer for VC 0 and the pointer for VC 1 are fully independent.
- Reset (synchronous, overrides all other behaviour):
  - vc_full = 00, buf = 0, rr_ptr[0] = rr_ptr[1] = 0
  - hence grant = 0, out_send = 0, out_data = 0
  - A reset mid-operation discards buffered flits; no grant or send occurs in the reset cycle.

## Timing
- Capture latency: a request granted in cycle t (polarity p) is stored at edge t.
- Earliest send: cycle t+1, when polarity = ~p and VC p is in drain phase, if out_ready = 1.
- Throughput: one flit per VC per two cycles, i.e. one flit per cycle on the link when both VCs are busy.
- grant, out_send and out_data are combinational from registers and inputs.
  - No combinational path from req_valid to out_send.
  - No combinational path from out_ready to grant.
- A VC filled at edge t cannot be granted again until it drains and its next fill phase comes round. Minimum refill cycle is t+2.
- rr_ptr wrap: a grant to index NUM_REQ-1 sets the pointer to 0.

## Test plan
- Reset:
  - Stimulus: assert reset for 2 cycles with req_valid = 5'b11111 and out_ready = 1.
  - Response: grant = 0, out_send = 0, out_data = 0, vc_full = 00 throughout; first grant after release goes to requester 0.
- Single flit:
  - Stimulus: polarity = 0, req_valid = 5'b00100, req_data[2] = 64'hA5.
  - Response: grant = 5'b00100, vc_full = 01 next cycle; at polarity = 1 with out_ready = 1, out_send = 1 and out_data = 64'hA5; vc_full = 00 afterwards.
- Round-robin with wrap:
  - Stimulus: all req_valid held high, out_ready = 1, polarity toggling.
  - Response: grants on even cycles go to 0, 1, 2, 3, 4, 0; grants on odd cycles follow an independent sequence 0, 1, 2, ….
- Backpressure:
  - Stimulus: fill vc0 with 64'h11, hold out_ready = 0 for 6 cycles.
  - Response: out_send = 0, vc_full[0] stays 1, grant = 0 in every polarity-0 cycle while vc1 still fills. Raising out_ready in a polarity-1 cycle sends 64'h11, and vc0 refills at the next polarity-0 cycle.
- Skipping idle requesters:
  - Stimulus: rr_ptr[0] = 3, req_valid = 5'b00011.
  - Response: grant = 5'b00001, rr_ptr[0] → 1.
- Reset mid-operation:
  - Stimulus: both VCs full, then assert reset for 1 cycle.
  - Response: no out_send in that cycle, vc_full = 00, and no stale data is ever sent afterwards.
